uart_byte_receiver: RTL

UART_BYTE_RECEIVER -- requirements
Module: uart_byte_receiver

---
 rtl/uart_byte_receiver.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver: synchronizes uart_rx, validates the start bit at mid-bit,
// samples eight data bits and the stop bit at bit centres, and flags framing errors.
module uart_byte_receiver #(
   parameter int DELAY_FRAMES = 234
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       uart_rx,
   output logic       byteReady,
   output logic [7:0] data,
   output logic       byteStrobe,
   output logic       frameError
);

   localparam logic [15:0] BIT_LAST  = 16'(DELAY_FRAMES - 1);
   localparam logic [15:0] HALF_LAST = 16'(DELAY_FRAMES / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      READ,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t      state;
   logic [15:0] counter;
   logic [2:0]  bitIndex;
   logic [7:0]  shift;
   logic        rxMeta;
   logic        rxSync;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
      end else begin
         rxMeta <= uart_rx;
         rxSync <= rxMeta;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         counter    <= '0;
         bitIndex   <= '0;
         shift      <= '0;
         data       <= '0;
         byteReady  <= 1'b1;
         byteStrobe <= 1'b0;
         frameError <= 1'b0;
      end else begin
         byteStrobe <= 1'b0;
         case (state)
            IDLE: begin
               counter <= '0;
               if (!rxSync) begin
                  state <= START;
               end
            end

            // A start bit still low at its centre is genuine; anything else was a glitch.
            START: begin
               if (counter == HALF_LAST) begin
                  counter  <= '0;
                  bitIndex <= '0;
                  if (!rxSync) begin
                     state     <= READ;
                     byteReady <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  counter <= counter + 16'd1;
               end
            end

            READ: begin
               if (counter == BIT_LAST) begin
                  counter          <= '0;
                  shift[bitIndex]  <= rxSync;
                  if (bitIndex == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bitIndex <= bitIndex + 3'd1;
                  end
               end else begin
                  counter <= counter + 16'd1;
               end
            end

            STOP: begin
               if (counter == BIT_LAST) begin
                  counter   <= '0;
                  byteReady <= 1'b1;
                  if (rxSync) begin
                     data       <= shift;
                     byteStrobe <= 1'b1;
                     frameError <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     frameError <= 1'b1;
                     state      <= WAIT_IDLE;
                  end
               end else begin
                  counter <= counter + 16'd1;
               end
            end

            // A held-low line (break) must return high before a new start is looked for.
            WAIT_IDLE: begin
               counter <= '0;
               if (rxSync) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
